// File: rtl/rmii_rx_framer_if.sv
// RMII receive pin bundle and framed dibit stream toward eth_rx.
// The PHY side drives crs_dv/rxd; the framer drives everything else.
interface rmii_rx_framer_if;
    logic       crs_dv;
    logic [1:0] rxd;
    logic       outclk;
    logic [1:0] out;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output crs_dv, rxd,
        input  outclk, out, done, err, busy
    );

    modport slave (
        input  crs_dv, rxd,
        output outclk, out, done, err, busy
    );
endinterface

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, forwards frame dibits
// with an end-of-frame pulse and flags framing faults.
module rmii_rx_framer #(
    parameter int MIN_PREAMBLE_DIBITS = 12,
    parameter int MAX_FRAME_DIBITS    = 6088
) (
    input  logic          clk,
    input  logic          rst,
    rmii_rx_framer_if.slave bus
);
    localparam int DW = $clog2(MAX_FRAME_DIBITS + 1);
    localparam int PW = $clog2(MIN_PREAMBLE_DIBITS + 1);
    localparam logic [DW-1:0] DMAX = DW'(MAX_FRAME_DIBITS);
    localparam logic [PW-1:0] PMIN = PW'(MIN_PREAMBLE_DIBITS);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } state_t;

    state_t          state_q;
    logic            s_dv_q;
    logic [1:0]      s_d_q;
    logic            h_dv_q;
    logic [1:0]      h_d_q;
    logic            pend_q;
    logic [PW-1:0]   pcnt_q;
    logic [DW-1:0]   dcnt_q;
    logic            outclk_q;
    logic [1:0]      out_q;
    logic            done_q;
    logic            err_q;
    logic            low_pair;

    // Two low samples in a row mark real loss of carrier.
    assign low_pair = !h_dv_q && !s_dv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            s_dv_q   <= 1'b0;
            s_d_q    <= 2'b00;
            h_dv_q   <= 1'b0;
            h_d_q    <= 2'b00;
            pend_q   <= 1'b0;
            pcnt_q   <= '0;
            dcnt_q   <= '0;
            outclk_q <= 1'b0;
            out_q    <= 2'b00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s_dv_q   <= bus.crs_dv;
            s_d_q    <= bus.rxd;
            h_dv_q   <= s_dv_q;
            h_d_q    <= s_d_q;
            outclk_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s_dv_q) begin
                        if (s_d_q == 2'b01) begin
                            state_q <= PRE;
                            pcnt_q  <= PW'(1);
                        end else if (s_d_q != 2'b00) begin
                            state_q <= DROP;
                        end
                    end
                end
                PRE: begin
                    if (!s_dv_q) begin
                        state_q <= IDLE;
                    end else if (s_d_q == 2'b01) begin
                        if (pcnt_q != PMIN) pcnt_q <= pcnt_q + PW'(1);
                    end else if (s_d_q == 2'b11 && pcnt_q >= PMIN) begin
                        state_q <= DATA;
                        dcnt_q  <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    // The hold stage holds the SFD on the first DATA cycle.
                    pend_q <= 1'b1;
                    if (pend_q) begin
                        if (low_pair) begin
                            done_q  <= 1'b1;
                            err_q   <= (dcnt_q[1:0] != 2'b00);
                            state_q <= IDLE;
                        end else if (dcnt_q == DMAX) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= DROP;
                        end else begin
                            outclk_q <= 1'b1;
                            out_q    <= h_d_q;
                            dcnt_q   <= dcnt_q + DW'(1);
                        end
                    end
                end
                DROP: begin
                    if (low_pair) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.outclk = outclk_q;
    assign bus.out    = out_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_rmii_rx_framer.sv
// Randomized scoreboard bench for rmii_rx_framer, two instances
// (default jabber limit and a 64-dibit limit) fed the same pins.
module tb_rmii_rx_framer;
    localparam int MIN  = 12;
    localparam int MAX0 = 6088;
    localparam int MAX1 = 64;

    typedef struct {
        bit         dn;
        logic [1:0] d;
        bit         e;
        int         cyc;
    } ev_t;

    bit         clk = 1'b0;
    logic       rst;
    logic       crs_dv;
    logic [1:0] rxd;
    int         cyc = 0;
    bit         mon_en;
    int         ab_dn;
    int         n_cmp;
    int         n_bad;
    bit         fdv[$];
    logic [1:0] fd[$];
    ev_t        q0[$];
    ev_t        q1[$];

    rmii_rx_framer_if b0 ();
    rmii_rx_framer_if b1 ();

    assign b0.crs_dv = crs_dv;
    assign b0.rxd    = rxd;
    assign b1.crs_dv = crs_dv;
    assign b1.rxd    = rxd;

    rmii_rx_framer #(
        .MIN_PREAMBLE_DIBITS(MIN),
        .MAX_FRAME_DIBITS(MAX0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(b0)
    );

    rmii_rx_framer #(
        .MIN_PREAMBLE_DIBITS(MIN),
        .MAX_FRAME_DIBITS(MAX1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm,
                       input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic clr();
        fdv.delete();
        fd.delete();
    endtask

    task automatic add(input bit v, input logic [1:0] d);
        fdv.push_back(v);
        fd.push_back(d);
    endtask

    task automatic add_pre(input int n);
        repeat (n) add(1'b1, 2'b01);
        add(1'b1, 2'b11);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) add(1'b1, b[2*k +: 2]);
    endtask

    task automatic add_idle(input int n);
        repeat (n) add(1'b0, 2'($urandom));
    endtask

    task automatic add_rand(input int n, input bit tog);
        for (int k = 0; k < n; k++) begin
            if (tog && $urandom_range(0, 5) == 0)
                add(1'b0, 2'($urandom));
            else
                add(1'b1, 2'($urandom));
        end
    endtask

    task automatic push(input int mx, input ev_t ev);
        if (mx == 0) q0.push_back(ev);
        else q1.push_back(ev);
    endtask

    function automatic bit dv_at(input int k);
        return (k < fdv.size()) ? fdv[k] : 1'b0;
    endfunction

    // First sample after two consecutive carrier-low samples past x.
    function automatic int drop_end(input int x);
        for (int m = x + 1; m < fdv.size(); m++)
            if (!fdv[m-1] && !fdv[m]) return m + 1;
        return fdv.size();
    endfunction

    // Reference: walk the frame buffer by the framing rules.
    task automatic model(input int mx, input int base, input int maxd);
        int  n;
        int  i;
        int  j;
        int  p;
        int  dc;
        bit  in_data;
        ev_t ev;
        n = fdv.size();
        i = 0;
        while (i < n) begin
            if (!fdv[i] || fd[i] == 2'b00) begin
                i++;
                continue;
            end
            if (fd[i] != 2'b01) begin
                i = drop_end(i);
                continue;
            end
            p = 1;
            i++;
            in_data = 1'b0;
            while (i < n) begin
                if (!fdv[i]) begin
                    i++;
                    break;
                end
                if (fd[i] == 2'b01) begin
                    p++;
                    i++;
                end else if (fd[i] == 2'b11 && p >= MIN) begin
                    in_data = 1'b1;
                    break;
                end else begin
                    i = drop_end(i);
                    break;
                end
            end
            if (!in_data) continue;
            dc = 0;
            j  = i + 1;
            i  = n;
            while (j < n) begin
                ev.cyc = base + j + 2;
                ev.d   = 2'b00;
                if (!fdv[j] && !dv_at(j + 1)) begin
                    ev.dn = 1'b1;
                    ev.e  = (dc % 4) != 0;
                    push(mx, ev);
                    i = j + 2;
                    break;
                end
                if (dc == maxd) begin
                    ev.dn = 1'b1;
                    ev.e  = 1'b1;
                    push(mx, ev);
                    i = drop_end(j + 1);
                    break;
                end
                ev.dn = 1'b0;
                ev.e  = 1'b0;
                ev.d  = fd[j];
                push(mx, ev);
                dc++;
                j++;
            end
        end
    endtask

    task automatic drive_frame(input bit expect_out);
        if (expect_out) begin
            model(0, cyc + 1, MAX0);
            model(1, cyc + 1, MAX1);
        end
        for (int k = 0; k < fdv.size(); k++) begin
            crs_dv = fdv[k];
            rxd    = fd[k];
            @(negedge clk);
        end
    endtask

    task automatic mon(input int mx, input logic oc,
                       input logic [1:0] o, input logic dn,
                       input logic er);
        ev_t h;
        int  sz;
        int  act;
        int  exp;
        sz  = (mx == 0) ? q0.size() : q1.size();
        act = dn ? (4 + int'(er)) : int'(o);
        if (oc || dn) begin
            chk(!(oc && dn), $sformatf("dut%0d_outclk_with_done", mx),
                1, 0);
            if (sz == 0) begin
                chk(1'b0, $sformatf("dut%0d_unexpected", mx), act, -1);
            end else begin
                h   = (mx == 0) ? q0.pop_front() : q1.pop_front();
                exp = h.dn ? (4 + int'(h.e)) : int'(h.d);
                chk(act == exp, $sformatf("dut%0d_event", mx), act, exp);
                chk(cyc == h.cyc, $sformatf("dut%0d_cycle", mx),
                    cyc, h.cyc);
            end
        end else if (sz > 0) begin
            h = (mx == 0) ? q0[0] : q1[0];
            if (h.cyc < cyc) begin
                h   = (mx == 0) ? q0.pop_front() : q1.pop_front();
                exp = h.dn ? (4 + int'(h.e)) : int'(h.d);
                chk(1'b0, $sformatf("dut%0d_missing", mx), -1, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mon_en) begin
                mon(0, b0.outclk, b0.out, b0.done, b0.err);
                mon(1, b1.outclk, b1.out, b1.done, b1.err);
            end else begin
                ab_dn += int'(b0.done) + int'(b1.done);
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({b0.outclk, b0.out, b0.done, b0.err, b0.busy} == 6'd0,
            {nm, "_dut0"},
            int'({b0.outclk, b0.out, b0.done, b0.err, b0.busy}), 0);
        chk({b1.outclk, b1.out, b1.done, b1.err, b1.busy} == 6'd0,
            {nm, "_dut1"},
            int'({b1.outclk, b1.out, b1.done, b1.err, b1.busy}), 0);
    endtask

    task automatic std_frame();
        add_pre(27);
        for (int b = 0; b < 64; b++) add_byte(8'(b));
        add_idle(4);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        ab_dn  = 0;
        mon_en = 1'b1;
        rst    = 1'b0;
        crs_dv = 1'b0;
        rxd    = 2'b00;

        repeat (8) begin
            @(negedge clk);
            crs_dv = ~crs_dv;
            rxd    = 2'($urandom);
            #1 chk_zero("in_reset");
        end
        @(negedge clk);
        rst    = 1'b1;
        crs_dv = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk(!b0.busy && !b1.busy, "busy_after_reset",
                int'({b0.busy, b1.busy}), 0);
        end

        clr();
        std_frame();
        drive_frame(1'b1);

        clr();
        add_pre(4);
        add_rand(40, 1'b0);
        add_idle(4);
        std_frame();
        drive_frame(1'b1);

        clr();
        add_pre(12);
        add_rand(60, 1'b0);
        add(1'b0, 2'($urandom));
        add(1'b1, 2'($urandom));
        add(1'b0, 2'($urandom));
        add(1'b1, 2'($urandom));
        add_idle(4);
        drive_frame(1'b1);

        clr();
        add_pre(14);
        add_rand(257, 1'b0);
        add_idle(4);
        add_pre(12);
        add_rand(100, 1'b0);
        add_idle(4);
        drive_frame(1'b1);

        repeat (12) begin
            clr();
            if ($urandom_range(0, 5) == 0) begin
                add(1'b1, 2'b10);
                add_rand(int'($urandom_range(1, 20)), 1'b1);
            end else begin
                repeat ($urandom_range(0, 3)) add(1'b1, 2'b00);
                add_pre(int'($urandom_range(8, 24)));
                add_rand(int'($urandom_range(0, 130)), 1'b1);
            end
            add_idle(4);
            drive_frame(1'b1);
        end

        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        clr();
        add_pre(20);
        add_rand(30, 1'b0);
        drive_frame(1'b0);
        #2 rst = 1'b0;
        crs_dv = 1'b0;
        #1 chk_zero("abort_reset");
        repeat (3) @(negedge clk);
        chk(ab_dn == 0, "abort_no_done", ab_dn, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        clr();
        std_frame();
        drive_frame(1'b1);

        for (int w = 0; w < 20; w++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        chk(q0.size() == 0, "dut0_drained", q0.size(), 0);
        chk(q1.size() == 0, "dut1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
